seven_segment_scan_ctrl: RTL and testbench



---
 rtl/seven_segment_pkg.sv | 22 ++
 rtl/seven_segment_scan_tick.sv | 44 ++++
 rtl/seven_segment_scan_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_seven_segment_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// -----------------------------------------------------------------------------
// seven_segment_pkg
// Shared definitions for the multiplexed seven-segment scan controller:
//   - scan_state_t : scan FSM state encoding
//   - SEG_BLANK    : active-low "all segments off" pattern
//   - DEF_*        : default DIGITS / TICK_DIV / BLANK_CYCLES values
// -----------------------------------------------------------------------------
package seven_segment_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam int DEF_DIGITS       = 4;
   localparam int DEF_TICK_DIV     = 50000;
   localparam int DEF_BLANK_CYCLES = 16;

endpackage

// File: rtl/seven_segment_scan_tick.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_tick
// Slot counter for the scan controller. Counts 0..TICK_DIV-1 while running and
// sits at 0 otherwise.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_run        : count when 1, clear to 0 when 0
//   o_slot_end   : current cycle is the last cycle of the slot
//   o_blank_end  : current cycle is the last dark cycle of the slot
//                  (never asserted when BLANK_CYCLES = 0)
// -----------------------------------------------------------------------------
module seven_segment_scan_tick #(
   parameter int TICK_DIV     = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_run,
   output logic o_slot_end,
   output logic o_blank_end
);

   localparam int            CW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST_CNT   = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!i_run || o_slot_end) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_slot_end  = (r_cnt == LAST_CNT);
   // With no dark time there is no last dark cycle; the guard also keeps the
   // wrapped BLANK_LAST constant from aliasing onto a real count.
   assign o_blank_end = (BLANK_CYCLES != 0) && (r_cnt == BLANK_LAST);

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_ctrl
// Time-multiplexes one external bin->seven-segment decoder across DIGITS
// common-anode digits. Each slot starts with BLANK_CYCLES dark cycles (bin is
// already updated, anodes off) followed by the lit part of the slot.
// A frame is latched from the pending register only at frame boundaries, so a
// displayed frame never mixes old and new values.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : scanning on when 1; 0 returns to IDLE on the next cycle
//   load         : capture value/dp into the pending register
//   value        : 4*DIGITS nibbles, digit 0 in the LSB nibble
//   dp           : decimal point per digit, 1 = lit
//   seg_in       : decoder output (active-low), combinational from bin
//   bin          : registered nibble to the decoder
//   seg_out      : segments to pins (active-low), seg_in gated by state
//   dp_n         : decimal point to pins (active-low)
//   an_n         : anode enables (active-low, at most one low)
//   frame_start  : one-cycle pulse on the first cycle of slot 0
//
// Build option: define SEG_SCAN_LZB_EN for leading-zero blanking.
// -----------------------------------------------------------------------------
module seven_segment_scan_ctrl
   import seven_segment_pkg::*;
#(
   parameter int DIGITS       = DEF_DIGITS,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp,
   input  logic [6:0]            seg_in,
   output logic [3:0]            bin,
   output logic [6:0]            seg_out,
   output logic                  dp_n,
   output logic [DIGITS-1:0]     an_n,
   output logic                  frame_start
);

   localparam int            IW       = $clog2(DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   scan_state_t            r_state;
   logic [IW-1:0]          r_idx;
   logic [3:0]             r_bin;
   logic [DIGITS-1:0]      r_an_n;
   logic                   r_dp_n;
   logic                   r_show;
   logic                   r_frame_start;
   logic [4*DIGITS-1:0]    r_act_val;
   logic [DIGITS-1:0]      r_act_dp;
   logic [4*DIGITS-1:0]    r_pnd_val;
   logic [DIGITS-1:0]      r_pnd_dp;
   logic                   r_pend;

   logic                   w_slot_end;
   logic                   w_blank_end;
   logic                   w_run;
   logic                   w_slot_start;
   logic                   w_frame_edge;
   logic [IW-1:0]          w_nxt_idx;
   logic [4*DIGITS-1:0]    w_new_val;
   logic [DIGITS-1:0]      w_new_dp;
   logic [3:0]             w_new_nib;
   logic                   w_lit_cur;
   logic                   w_lit_new;

   seven_segment_scan_tick #(
      .TICK_DIV     (TICK_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_tick (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_run       (w_run),
      .o_slot_end  (w_slot_end),
      .o_blank_end (w_blank_end)
   );

   // The counter only runs inside a slot; in IDLE it rests at 0 so the first
   // slot after enable starts from count 0.
   assign w_run        = enable && (r_state != ST_IDLE);
   assign w_slot_start = enable && ((r_state == ST_IDLE) || w_slot_end);
   assign w_frame_edge = enable && ((r_state == ST_IDLE) ||
                                    (w_slot_end && (r_idx == LAST_IDX)));
   assign w_nxt_idx    = ((r_state == ST_IDLE) || (r_idx == LAST_IDX)) ?
                         '0 : r_idx + IW'(1);

   // Frame contents that will be active after this edge. A load coinciding
   // with the boundary bypasses pending and goes straight into the new frame.
   assign w_new_val = !w_frame_edge ? r_act_val :
                      load          ? value     :
                      r_pend        ? r_pnd_val : r_act_val;
   assign w_new_dp  = !w_frame_edge ? r_act_dp  :
                      load          ? dp        :
                      r_pend        ? r_pnd_dp  : r_act_dp;
   assign w_new_nib = w_new_val[{w_nxt_idx, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
   // A digit is lit if it is digit 0, has its dp set, or some nibble at or
   // above it is nonzero.
   function automatic logic f_lit(input logic [4*DIGITS-1:0] v,
                                  input logic [DIGITS-1:0]   d,
                                  input logic [IW-1:0]       k);
      logic lit;
      lit = (k == '0) || d[k];
      for (int j = 0; j < DIGITS; j++) begin
         if ((j >= int'(k)) && (v[4*j +: 4] != 4'h0)) lit = 1'b1;
      end
      return lit;
   endfunction

   assign w_lit_cur = f_lit(r_act_val, r_act_dp, r_idx);
   assign w_lit_new = f_lit(w_new_val, w_new_dp, w_nxt_idx);
`else
   assign w_lit_cur = 1'b1;
   assign w_lit_new = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_idx         <= '0;
         r_bin         <= 4'h0;
         r_an_n        <= '1;
         r_dp_n        <= 1'b1;
         r_show        <= 1'b0;
         r_frame_start <= 1'b0;
         r_act_val     <= '0;
         r_act_dp      <= '0;
         r_pnd_val     <= '0;
         r_pnd_dp      <= '0;
         r_pend        <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;

         if (load) begin
            r_pnd_val <= value;
            r_pnd_dp  <= dp;
            r_pend    <= 1'b1;
         end

         if (!enable) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_an_n  <= '1;
            r_dp_n  <= 1'b1;
            r_show  <= 1'b0;
         end else if (w_slot_start) begin
            r_idx <= w_nxt_idx;
            r_bin <= w_new_nib;
            if (w_frame_edge) begin
               // Pending is consumed here; this overrides the set above.
               r_act_val     <= w_new_val;
               r_act_dp      <= w_new_dp;
               r_pend        <= 1'b0;
               r_frame_start <= 1'b1;
            end
            if (BLANK_CYCLES == 0) begin
               r_state <= ST_SHOW;
               r_an_n  <= w_lit_new ? ~(DIGITS'(1) << w_nxt_idx) : '1;
               r_dp_n  <= ~(w_lit_new & w_new_dp[w_nxt_idx]);
               r_show  <= w_lit_new;
            end else begin
               r_state <= ST_BLANK;
               r_an_n  <= '1;
               r_dp_n  <= 1'b1;
               r_show  <= 1'b0;
            end
         end else if ((r_state == ST_BLANK) && w_blank_end) begin
            r_state <= ST_SHOW;
            r_an_n  <= w_lit_cur ? ~(DIGITS'(1) << r_idx) : '1;
            r_dp_n  <= ~(w_lit_cur & r_act_dp[r_idx]);
            r_show  <= w_lit_cur;
         end
      end
   end

   // Zero-latency path: decoder output passes straight through while lit.
   assign seg_out     = r_show ? seg_in : SEG_BLANK;
   assign bin         = r_bin;
   assign an_n        = r_an_n;
   assign dp_n        = r_dp_n;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_scan_ctrl
// Directed bench for seven_segment_scan_ctrl with DIGITS=4, TICK_DIV=8,
// BLANK_CYCLES=2. Expected per-cycle outputs are tagged with the cycle number
// they belong to and queued; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_seven_segment_scan_ctrl;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [6:0]  seg_in;
   logic [3:0]  bin;
   logic [6:0]  seg_out;
   logic        dp_n;
   logic [3:0]  an_n;
   logic        frame_start;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // {tag[15:0], chk_bin, an_n[3:0], dp_n, seg[6:0], bin[3:0], frame_start}
   logic [33:0] exp_q[$];

`ifdef SEG_SCAN_LZB_EN
   localparam logic [3:0] MASK_0000 = 4'b0001;
   localparam logic [3:0] MASK_0042 = 4'b1011;
`else
   localparam logic [3:0] MASK_0000 = 4'b1111;
   localparam logic [3:0] MASK_0042 = 4'b1111;
`endif

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // External decoder stand-in (active-low gfedcba).
   function automatic logic [6:0] dec7(input logic [3:0] b);
      case (b)
         4'h0: dec7 = 7'h40;  4'h1: dec7 = 7'h79;  4'h2: dec7 = 7'h24;  4'h3: dec7 = 7'h30;
         4'h4: dec7 = 7'h19;  4'h5: dec7 = 7'h12;  4'h6: dec7 = 7'h02;  4'h7: dec7 = 7'h78;
         4'h8: dec7 = 7'h00;  4'h9: dec7 = 7'h10;  4'hA: dec7 = 7'h08;  4'hB: dec7 = 7'h03;
         4'hC: dec7 = 7'h46;  4'hD: dec7 = 7'h21;  4'hE: dec7 = 7'h06;  default: dec7 = 7'h0E;
      endcase
   endfunction

   assign seg_in = dec7(bin);

   seven_segment_scan_ctrl #(
      .DIGITS       (4),
      .TICK_DIV     (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .load        (load),
      .value       (value),
      .dp          (dp),
      .seg_in      (seg_in),
      .bin         (bin),
      .seg_out     (seg_out),
      .dp_n        (dp_n),
      .an_n        (an_n),
      .frame_start (frame_start)
   );

   // ---------------- driver / expectation tasks ----------------
   task automatic go_to(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input int tag, input logic chk, input logic [3:0] an,
                           input logic dpn, input logic [6:0] seg,
                           input logic [3:0] b, input logic fs);
      exp_q.push_back({16'(tag), chk, an, dpn, seg, b, fs});
   endtask

   task automatic exp_idle(input int tag, input logic chk, input logic [3:0] b);
      push_exp(tag, chk, 4'hF, 1'b1, 7'h7F, b, 1'b0);
   endtask

   // One slot: 2 dark cycles then lit cycles (or dark throughout if !lit).
   task automatic exp_slot(input int tag, input int idx, input logic [3:0] nib,
                           input logic dpb, input logic fs, input logic lit,
                           input int len);
      logic [3:0] one;
      one = 4'b0001;
      for (int i = 0; i < len; i++) begin
         if ((i < 2) || !lit)
            push_exp(tag + i, 1'b1, 4'hF, 1'b1, 7'h7F, nib, fs && (i == 0));
         else
            push_exp(tag + i, 1'b1, ~(one << idx), ~dpb, dec7(nib), nib, 1'b0);
      end
   endtask

   task automatic exp_frame(input int tag, input logic [15:0] v,
                            input logic [3:0] d, input logic [3:0] mask);
      for (int k = 0; k < 4; k++)
         exp_slot(tag + 8 * k, k, v[4*k +: 4], d[k], (k == 0), mask[k], 8);
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [33:0] e;
      while ((exp_q.size() > 0) && (int'(exp_q[0][33:18]) < cyc)) begin
         e = exp_q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL missed_tag tag=%0d at cyc=%0d", e[33:18], cyc);
      end
      if ((exp_q.size() > 0) && (int'(exp_q[0][33:18]) == cyc)) begin
         e = exp_q.pop_front();
         n_tests++;
         if ((an_n !== e[16:13]) || (dp_n !== e[12]) || (seg_out !== e[11:5]) ||
             (frame_start !== e[0]) || (e[17] && (bin !== e[4:1]))) begin
            n_fail++;
            $display("FAIL cyc_%0d got an_n=%b dp_n=%b seg=%h bin=%h fs=%b exp an_n=%b dp_n=%b seg=%h bin=%h(chk=%b) fs=%b",
                     cyc, an_n, dp_n, seg_out, bin, frame_start,
                     e[16:13], e[12], e[11:5], e[4:1], e[17], e[0]);
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog cyc=%0d exp_q_left=%0d", cyc, exp_q.size());
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int f1, f2, f3, f4, f5, f6, f7, f8;
      rst_n  = 1'b0;
      enable = 1'b0;
      load   = 1'b0;
      value  = 16'h0;
      dp     = 4'h0;

      // Reset values while held in reset.
      repeat (3) @(posedge clk);
      #1;
      exp_idle(cyc, 1'b1, 4'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_idle(cyc, 1'b1, 4'h0);          // idle with enable=0

      // Enable + load 1234: first frame starts on the next edge.
      enable = 1'b1;
      load   = 1'b1;
      value  = 16'h1234;
      dp     = 4'h0;
      f1 = cyc + 1;
      f2 = f1 + 32;
      f3 = f2 + 32;
      f4 = f3 + 32;
      f5 = f4 + 32;
      exp_frame(f1, 16'h1234, 4'h0, 4'hF);
      exp_frame(f2, 16'h1234, 4'h0, 4'hF);
      @(posedge clk); #1;
      load = 1'b0;

      // Load ABCD mid slot 2 of frame 2: frame 2 unaffected, frame 3 shows it.
      go_to(f2 + 18);
      load  = 1'b1;
      value = 16'hABCD;
      exp_frame(f3, 16'hABCD, 4'h0, 4'hF);
      go_to(f2 + 19);
      load = 1'b0;

      // Load 5678 on the final cycle of slot 3: next frame shows it at once.
      go_to(f3 + 31);
      load  = 1'b1;
      value = 16'h5678;
      exp_frame(f4, 16'h5678, 4'h0, 4'hF);
      // Frame 5: slot 0 full, slot 1 cut short by enable drop in SHOW.
      exp_slot(f5, 0, 4'h8, 1'b0, 1'b1, 1'b1, 8);
      exp_slot(f5 + 8, 1, 4'h7, 1'b0, 1'b0, 1'b1, 4);
      exp_idle(f5 + 12, 1'b0, 4'h0);
      exp_idle(f5 + 13, 1'b0, 4'h0);
      go_to(f3 + 32);
      load = 1'b0;

      go_to(f5 + 11);
      enable = 1'b0;
      // Load while disabled goes to pending and is picked up on re-enable.
      go_to(f5 + 12);
      load  = 1'b1;
      value = 16'h9876;
      dp    = 4'b0101;
      go_to(f5 + 13);
      load   = 1'b0;
      enable = 1'b1;
      f6 = f5 + 14;
      exp_slot(f6, 0, 4'h6, 1'b1, 1'b1, 1'b1, 8);
      exp_slot(f6 + 8, 1, 4'h7, 1'b0, 1'b0, 1'b1, 4);

      // Asynchronous reset mid-SHOW of slot 1: visible before the next edge.
      go_to(f6 + 12);
      rst_n = 1'b0;
      exp_idle(f6 + 12, 1'b1, 4'h0);
      exp_idle(f6 + 13, 1'b1, 4'h0);
      go_to(f6 + 13);
      rst_n = 1'b1;
      f7 = f6 + 14;
      // Active and pending were cleared, enable still high: zeros shown.
      exp_frame(f7, 16'h0000, 4'h0, MASK_0000);

      // Leading-zero case.
      go_to(f7 + 10);
      load  = 1'b1;
      value = 16'h0042;
      dp    = 4'b1000;
      f8 = f7 + 32;
      exp_frame(f8, 16'h0042, 4'b1000, MASK_0042);
      go_to(f7 + 11);
      load = 1'b0;

      go_to(f8 + 34);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain got %0d entries left, exp 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
